// File: rtl/ifb_pkg.sv
// Shared constants, FSM state encoding and FIFO entry layout for the instruction fetch buffer.
package ifb_pkg;

    localparam int DEPTH = 4;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [31:0] NOP          = 32'h0000_0000;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DROP = 2'd2
    } ifb_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ifb_entry_t;

endpackage

// File: rtl/ifb_fifo.sv
// DEPTH-entry {pc, inst} FIFO with synchronous clear; clear wins over push and pop.
module ifb_fifo
    import ifb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  ifb_entry_t       wdata,
    output ifb_entry_t       head,
    output logic [CNT_W-1:0] count
);

    ifb_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !clear && (count < CNT_W'(DEPTH));
    assign do_pop  = pop && !clear && (count != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is only used while count is non-zero.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/inst_fetch_buffer.sv
// Instruction prefetch buffer: one-outstanding-request fetch FSM feeding a small FIFO.
// Optional IFB_PERF_EN adds perf_fetched / perf_dropped event counters.
module inst_fetch_buffer
    import ifb_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
`ifdef IFB_PERF_EN
    output logic [15:0] perf_fetched,
    output logic [15:0] perf_dropped,
`endif
    output ifb_state_e  fetch_state
);

    ifb_state_e       state;
    ifb_state_e       next_state;
    logic [31:0]      fetch_pc;
    logic [31:0]      req_addr;
    logic             issue;
    logic             push;
    logic             pop;
    logic             drop_ack;
    logic [CNT_W-1:0] count;
    ifb_entry_t       head;
    ifb_entry_t       wdata;

    // Handshakes: the core pops the head when inst_valid && inst_ready at a rising edge;
    // memory completes the single outstanding request when imem_ack is high at a rising edge.

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // Only IDLE issues, so no request is in flight when the space check is made.
    always_comb begin
        next_state = state;
        issue      = 1'b0;
        push       = 1'b0;
        drop_ack   = 1'b0;
        case (state)
            S_IDLE: begin
                if (!redirect && (count < CNT_W'(DEPTH))) begin
                    next_state = S_REQ;
                    issue      = 1'b1;
                end
            end
            S_REQ: begin
                if (imem_ack) begin
                    next_state = S_IDLE;
                    push       = !redirect;
                    drop_ack   = redirect;
                end else if (redirect) begin
                    next_state = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_ack) begin
                    next_state = S_IDLE;
                    drop_ack   = 1'b1;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_VECTOR;
            req_addr <= 32'h0000_0000;
        end else begin
            if (redirect)  fetch_pc <= {redirect_pc[31:2], 2'b00};
            else if (push) fetch_pc <= fetch_pc + 32'd4;
            // Latched at issue so the address stays put even if a redirect moves fetch_pc.
            if (issue) req_addr <= fetch_pc;
        end
    end

    assign wdata.pc   = req_addr;
    assign wdata.inst = imem_rdata;
    assign pop        = inst_valid && inst_ready && !redirect;

    ifb_fifo u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (redirect),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .head  (head),
        .count (count)
    );

    assign inst_valid  = (count != '0);
    assign inst        = inst_valid ? head.inst : NOP;
    assign inst_pc     = inst_valid ? head.pc : 32'h0000_0000;
    assign imem_req    = (state != S_IDLE);
    assign imem_addr   = req_addr;
    assign fetch_state = state;

`ifdef IFB_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched <= 16'h0000;
            perf_dropped <= 16'h0000;
        end else begin
            if (push) perf_fetched <= perf_fetched + 16'd1;
            perf_dropped <= perf_dropped + 16'(drop_ack) + (redirect ? 16'(count) : 16'd0);
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Randomized bench for inst_fetch_buffer with a queue-based fetch-stream model and decoupled monitor.
module tb_inst_fetch_buffer;
    import ifb_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    ifb_state_e  fetch_state;
`ifdef IFB_PERF_EN
    logic [15:0] perf_fetched;
    logic [15:0] perf_dropped;
`endif

    inst_fetch_buffer dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
`ifdef IFB_PERF_EN
        .perf_fetched(perf_fetched),
        .perf_dropped(perf_dropped),
`endif
        .fetch_state (fetch_state)
    );

    always #5 clk = ~clk;

    // Scoreboard: entries the buffer should currently hold, oldest first, as {pc, inst}.
    logic [63:0] exp_q[$];
    int          errors = 0;
    int          checks = 0;

    // Reference model of the fetch stream.
    logic [31:0] model_pc    = 32'h0;
    logic        outstanding = 1'b0;
    logic        stale       = 1'b0;
    logic [31:0] cur_addr    = 32'h0;
    logic        prev_idle   = 1'b0;
    int          prev_size   = 0;
    logic        prev_redir  = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pick_redirect_pc();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'h0040_0013;
            2:       return (32'hFFFF_FFFC - 32'($urandom_range(0, 2)) * 32'd4) | 32'($urandom_range(0, 3));
            default: return 32'($urandom_range(0, 255)) << 2;
        endcase
    endfunction

    // One cycle: observe after the previous edge, then choose inputs for the next edge.
    task automatic drive_cycle(input int ack_pct, input int ready_pct, input int redir_pct,
                               input bit force_redir, input logic [31:0] force_pc);
        logic        exp_req;
        logic        ack;
        logic        redir;
        logic [31:0] rpc;
        logic [31:0] exp_state;
        @(negedge clk);
        #1;
        exp_req = outstanding || (prev_idle && (prev_size < DEPTH) && !prev_redir);
        check("imem_req", 32'(imem_req), 32'(exp_req));
        if (imem_req && !outstanding) begin
            check("req_addr", imem_addr, model_pc);
            outstanding = 1'b1;
            stale       = 1'b0;
            cur_addr    = model_pc;
        end else if (outstanding) begin
            check("addr_hold", imem_addr, cur_addr);
        end
        exp_state = outstanding ? (stale ? 32'(S_DROP) : 32'(S_REQ)) : 32'(S_IDLE);
        check("state", 32'(fetch_state), exp_state);

        ack   = outstanding && ($urandom_range(0, 99) < ack_pct);
        redir = force_redir || ($urandom_range(0, 99) < redir_pct);
        rpc   = force_redir ? force_pc : pick_redirect_pc();

        prev_idle  = !outstanding;
        prev_size  = exp_q.size();
        prev_redir = redir;

        imem_ack    = ack;
        imem_rdata  = ack ? mem_word(cur_addr) : $urandom;
        redirect    = redir;
        redirect_pc = redir ? rpc : $urandom;
        inst_ready  = ($urandom_range(0, 99) < ready_pct);

        if (redir) begin
            exp_q.delete();
            model_pc = {rpc[31:2], 2'b00};
            if (outstanding) begin
                if (ack) begin
                    outstanding = 1'b0;
                    stale       = 1'b0;
                end else begin
                    stale = 1'b1;
                end
            end
        end else if (ack) begin
            if (!stale) begin
                exp_q.push_back({cur_addr, mem_word(cur_addr)});
                model_pc = model_pc + 32'd4;
            end
            outstanding = 1'b0;
            stale       = 1'b0;
        end
    endtask

    // Assert reset for a few cycles; optionally ack on the first edge after release.
    task automatic apply_reset(input bit ack_after);
        @(negedge clk);
        #1;
        reset      = 1'b1;
        imem_ack   = 1'b0;
        redirect   = 1'b0;
        inst_ready = 1'b0;
        exp_q.delete();
        model_pc    = 32'h0;
        outstanding = 1'b0;
        stale       = 1'b0;
        #1;
        check("rst_imem_req", 32'(imem_req), 32'h0);
        check("rst_imem_addr", imem_addr, 32'h0);
        check("rst_inst", inst, NOP);
        check("rst_inst_pc", inst_pc, 32'h0);
        check("rst_inst_valid", 32'(inst_valid), 32'h0);
        check("rst_state", 32'(fetch_state), 32'(S_IDLE));
        repeat (2) @(negedge clk);
        #1;
        reset      = 1'b0;
        imem_ack   = ack_after;
        imem_rdata = 32'hDEAD_BEEF;
        inst_ready = 1'b1;
        prev_idle  = 1'b1;
        prev_size  = 0;
        prev_redir = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever the core consumes the head.
    initial begin
        logic        pv;
        logic [31:0] pi;
        logic [31:0] pp;
        logic [63:0] e;
        pv = 1'b0;
        pi = 32'h0;
        pp = 32'h0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pv = 1'b0;
            end else begin
                if (pv && inst_ready && !redirect) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pop_unexpected: got pc %h with nothing expected", pp);
                    end else begin
                        e = exp_q.pop_front();
                        check("pop_pc", pp, e[63:32]);
                        check("pop_inst", pi, e[31:0]);
                    end
                end
                check("inst_valid", 32'(inst_valid), 32'(exp_q.size() != 0));
                if (!inst_valid) begin
                    check("nop_inst", inst, NOP);
                    check("nop_pc", inst_pc, 32'h0);
                end
                pv = inst_valid;
                pi = inst;
                pp = inst_pc;
            end
        end
    end

    initial begin
        apply_reset(1'b0);
        // Streaming: every request acked on the cycle after issue, core always ready.
        repeat (200) drive_cycle(100, 100, 0, 1'b0, 32'h0);
        // Back-pressure: fill the buffer, then trickle pops.
        repeat (60) drive_cycle(100, 0, 0, 1'b0, 32'h0);
        repeat (40) drive_cycle(100, 30, 0, 1'b0, 32'h0);
        // Address wrap at the top of memory.
        drive_cycle(100, 0, 0, 1'b1, 32'hFFFF_FFFC);
        repeat (12) drive_cycle(100, 0, 0, 1'b0, 32'h0);
        repeat (10) drive_cycle(100, 100, 0, 1'b0, 32'h0);
        // Redirect with misaligned target while a request is held pending.
        repeat (8) drive_cycle(0, 100, 0, 1'b0, 32'h0);
        drive_cycle(0, 100, 0, 1'b1, 32'h0040_0013);
        repeat (20) drive_cycle(60, 100, 0, 1'b0, 32'h0);
        // Mixed random traffic.
        repeat (600) drive_cycle(60, 60, 8, 1'b0, 32'h0);
        // Reset in the middle of an outstanding request, stray ack right after release.
        for (int i = 0; i < 10 && !outstanding; i++) drive_cycle(0, 50, 0, 1'b0, 32'h0);
        apply_reset(1'b1);
        repeat (400) drive_cycle(50, 70, 25, 1'b0, 32'h0);
        repeat (20) drive_cycle(100, 100, 0, 1'b0, 32'h0);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
